// File: rtl/uart_rx_telemetry_if.sv
// Parallel consumer-side bus of the telemetry UART receiver: ready/acknowledge handshake plus the received byte.
// The frame-error flag exists only when UART_FRAME_ERR_EN is defined.
interface uart_rx_telemetry_if;
    logic       clr_rdy;
    logic       rdy;
    logic [7:0] rx_data;
`ifdef UART_FRAME_ERR_EN
    logic       frm_err;

    modport master (input clr_rdy, output rdy, output rx_data, output frm_err);
    modport slave  (output clr_rdy, input rdy, input rx_data, input frm_err);
`else
    modport master (input clr_rdy, output rdy, output rx_data);
    modport slave  (output clr_rdy, input rdy, input rx_data);
`endif
endinterface

// File: rtl/uart_rx_telemetry.sv
// 8N1 UART receiver for the eBike telemetry stream, parameterised by clocks per bit (BAUD_DIV).
// Optional stop-bit checking is enabled by defining UART_FRAME_ERR_EN.
module uart_rx_telemetry #(
    parameter int BAUD_DIV = 2604
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RX,
    uart_rx_telemetry_if.master   bus
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic          rx_meta, rx_s, rx_prev;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          start_edge, sample, stop_done;
    logic          rdy_q;
    logic [7:0]    data_q;

    // Synchronizer presets to idle-high so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            shift   <= shift_nxt;
        end
    end

    assign start_edge = (state == IDLE) && rx_prev && !rx_s;
    assign sample     = (state != IDLE) && (cnt == '0);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        stop_done   = 1'b0;

        if (state != IDLE) begin
            cnt_nxt = sample ? FULL_LOAD : cnt - CW'(1);
        end

        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_nxt = START;
                    cnt_nxt   = HALF_LOAD;
                end
            end
            START: begin
                if (sample) begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_nxt   = {rx_s, shift[7:1]};
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (sample) begin
                    stop_done = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // A new byte landing wins over a same-cycle acknowledge or start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q  <= 1'b0;
            data_q <= 8'h00;
        end else begin
            if (stop_done) begin
                rdy_q  <= 1'b1;
                data_q <= shift;
            end else if (bus.clr_rdy || start_edge) begin
                rdy_q <= 1'b0;
            end
        end
    end

    assign bus.rdy     = rdy_q;
    assign bus.rx_data = data_q;

`ifdef UART_FRAME_ERR_EN
    logic ferr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ferr_q <= 1'b0;
        end else if (stop_done) begin
            ferr_q <= ~rx_s;
        end
    end

    assign bus.frm_err = ferr_q;
`endif
endmodule

// File: tb/tb_uart_rx_telemetry.sv
// Self-checking bench for uart_rx_telemetry: frame-level reference model plus directed literal checks.
// Build with UART_FRAME_ERR_EN defined to also cover the stop-bit error flag.
module tb_uart_rx_telemetry;
    localparam int B = 16;
    localparam int H = B / 2;
    localparam int DELIVER_LAT = 3 + H + 9 * B;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic tie = 1'b0;
    logic clr_drv = 1'b0;
    int   clr_mode = 0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    uart_rx_telemetry_if bus();
    assign bus.clr_rdy = tie ? bus.rdy : clr_drv;

    uart_rx_telemetry #(.BAUD_DIV(B)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RX    (rx),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [7:0] d;
        logic       stop;
    } del_t;

    int   det_q[$];
    del_t del_q[$];
    logic       exp_rdy = 1'b0;
    logic [7:0] exp_data = 8'h00;
    logic       exp_ferr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: each frame is reduced to a start-detection cycle and a delivery cycle.
    always @(posedge clk or negedge rst_n) begin
        int   now;
        logic clr, set, det;
        if (!rst_n) begin
            exp_rdy  = 1'b0;
            exp_data = 8'h00;
            exp_ferr = 1'b0;
            det_q.delete();
            del_q.delete();
        end else begin
            now = cyc + 1;
            clr = tie ? exp_rdy : clr_drv;
            set = 1'b0;
            det = 1'b0;
            if (det_q.size() > 0 && det_q[0] == now) begin
                det = 1'b1;
                void'(det_q.pop_front());
            end
            if (del_q.size() > 0 && del_q[0].c == now) begin
                set      = 1'b1;
                exp_data = del_q[0].d;
                exp_ferr = ~del_q[0].stop;
                void'(del_q.pop_front());
            end
            if (set) exp_rdy = 1'b1;
            else if (clr || det) exp_rdy = 1'b0;
        end
    end

    always @(negedge clk) begin
        check("rdy", 32'(bus.rdy), 32'(exp_rdy));
        check("rx_data", 32'(bus.rx_data), 32'(exp_data));
`ifdef UART_FRAME_ERR_EN
        check("frm_err", 32'(bus.frm_err), 32'(exp_ferr));
`endif
    end

    int   rise_q[$];
    int   hi_cnt = 0;
    logic rdy_last = 1'b0;
    always @(negedge clk) begin
        if (bus.rdy && !rdy_last) rise_q.push_back(cyc);
        if (bus.rdy) hi_cnt++;
        rdy_last = bus.rdy;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            clr_drv = (clr_mode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
        end
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_mode(input int m);
        clr_mode = m;
        tie = (m == 1);
    endtask

    int last_start = 0;

    task automatic applyStimulus(input logic [7:0] d, input logic stop, input int gap);
        int n;
        rx = 1'b0;
        n = cyc;
        last_start = n;
        det_q.push_back(n + 3);
        del_q.push_back('{c: n + DELIVER_LAT, d: d, stop: stop});
        tick(B);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(B);
        end
        rx = stop;
        tick(B);
        rx = 1'b1;
        tick(gap);
    endtask

    task automatic send_glitch(input int len);
        rx = 1'b0;
        det_q.push_back(cyc + 3);
        tick(len);
        rx = 1'b1;
        tick(2 * B);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] data, input logic rdy);
        check({name, "_data"}, 32'(bus.rx_data), 32'(data));
        check({name, "_rdy"}, 32'(bus.rdy), 32'(rdy));
    endtask

    initial begin
        $display("[TB] start, BAUD_DIV=%0d", B);
        tick(3);
        checkOutput("reset", 8'h00, 1'b0);
        rst_n = 1'b1;
        tick(4);

        // Single frame with acknowledge tied to ready: one-cycle pulse 155 cycles after the line edge.
        set_mode(1);
        rise_q.delete();
        hi_cnt = 0;
        applyStimulus(8'hAA, 1'b1, 2 * B);
        check("tie_pulses", 32'(rise_q.size()), 32'd1);
        check("tie_width", 32'(hi_cnt), 32'd1);
        if (rise_q.size() > 0) check("tie_latency", 32'(rise_q[0] - last_start), 32'd155);
        checkOutput("tie", 8'hAA, 1'b0);

        // Back-to-back frames land exactly ten bit periods apart.
        rise_q.delete();
        applyStimulus(8'hAA, 1'b1, 0);
        applyStimulus(8'h55, 1'b1, 2 * B);
        check("b2b_pulses", 32'(rise_q.size()), 32'd2);
        if (rise_q.size() == 2) check("b2b_spacing", 32'(rise_q[1] - rise_q[0]), 32'd160);
        checkOutput("b2b", 8'h55, 1'b0);

        // No acknowledge: ready drops only at the next start edge.
        set_mode(0);
        rise_q.delete();
        applyStimulus(8'h0A, 1'b1, 0);
        applyStimulus(8'hBC, 1'b1, 2 * B);
        check("hold_rises", 32'(rise_q.size()), 32'd2);
        checkOutput("hold", 8'hBC, 1'b1);

        send_glitch(B / 4);
        checkOutput("glitch", 8'hBC, 1'b0);

        // Reset in the middle of data bit 4.
        rx = 1'b0;
        det_q.push_back(cyc + 3);
        tick(B);
        for (int i = 0; i < 4; i++) begin
            rx = 1'(8'hF0 >> i);
            tick(B);
        end
        tick(H);
        rst_n = 1'b0;
        rx = 1'b1;
        tick(2);
        checkOutput("midreset", 8'h00, 1'b0);
        tick(3);
        rst_n = 1'b1;
        tick(B);
        applyStimulus(8'h3C, 1'b1, 2 * B);
        checkOutput("after_reset", 8'h3C, 1'b1);

`ifdef UART_FRAME_ERR_EN
        applyStimulus(8'h81, 1'b0, B);
        checkOutput("bad_stop", 8'h81, 1'b1);
        check("bad_stop_ferr", 32'(bus.frm_err), 32'd1);
        applyStimulus(8'h55, 1'b1, B);
        check("good_stop_ferr", 32'(bus.frm_err), 32'd0);
`endif

        for (int f = 0; f < 40; f++) begin
            logic [7:0] d;
            logic       stop;
            int         gap;
            set_mode($urandom_range(0, 2));
            d = 8'($urandom());
            stop = ($urandom_range(0, 5) != 0);
            gap = $urandom_range(0, 2 * B);
            if (!stop && gap == 0) gap = 1;
            if ($urandom_range(0, 7) == 0) send_glitch($urandom_range(1, H - 1));
            applyStimulus(d, stop, gap);
        end
        tick(2 * B);
        check("pending_deliveries", 32'(del_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_telemetry.md
# uart_rx_telemetry

Serial 8N1 UART receiver that deserializes the eBike telemetry stream (delimiters 0xAA, 0x55, then 12-bit payloads sent high byte first). It sits on the bench/host side of the telemetry `TX` line. It presents each received byte on a parallel bus with a ready flag that the consumer clears. It is parameterized by clocks-per-bit, so it can track the transmitter's baud divisor.

## Interface
- `BAUD_DIV`, default 2604: clocks per bit period; must be ≥ 16 and even.
- `clk` input 1: system clock, all logic on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `RX` input 1: serial line; idles high; asynchronous to `clk`.
- `clr_rdy` input 1: consumer acknowledge; clears `rdy`.
- `rdy` output 1: high when `rx_data` holds a newly received byte.
- `rx_data` output 8: last received byte, LSB received first.
- `frm_err` output 1: present only with `UART_FRAME_ERR_EN`; high when the last frame's stop bit sampled 0.

## Operation
- `RX` is passed through a 2-flop synchronizer. Both flops preset to 1 on reset. All logic uses the synchronized value `rx_s`.
- Start detection: a falling edge of `rx_s` (previous 1, current 0) in IDLE moves the FSM to START. On entry the baud counter is loaded with `BAUD_DIV/2 - 1`.
- Baud counter counts down. At count 0 a sample is taken and the counter reloads with `BAUD_DIV - 1`.
- FSM states:
  - IDLE: waits for start edge.
  - START: at the first sample, if `rx_s`=1 it is a false start and the FSM returns to IDLE with no output change. Otherwise it goes to DATA with bit count 0.
  - DATA: each sample right-shifts `rx_s` into the MSB of an 8-bit shift register and increments the bit count. After the 8th sample it goes to STOP.
  - STOP: at the sample, `rx_data` is loaded from the shift register and `rdy` is set. With the macro, `frm_err` is set to `~rx_s`. The FSM returns to IDLE.
- The byte is delivered regardless of stop-bit value.
- `rdy` clears on `clr_rdy`=1, or on detection of a new start edge. If set and clear occur in the same cycle, set wins.
- `rx_data` changes only on stop-bit sample. It holds its value through subsequent idle time and through the next reception until that reception completes.
- Back-to-back frames: a start edge is accepted the first cycle after returning to IDLE, so a frame whose start bit immediately follows the stop bit is received.
- `clr_rdy` tied directly to `rdy` is legal. `rdy` is then a 1-cycle pulse, and `rx_data` remains stable afterward.

## Timing
- Reset values:
  - `rdy`=0, `rx_data`=0x00, `frm_err`=0.
  - FSM in IDLE, counters 0, synchronizer=1.
- Reset asserted mid-frame aborts the frame immediately. Outputs go to reset values, and the next falling edge after release starts a fresh frame.
- Start-edge detection occurs 2 clocks after the RX falling edge (synchronizer latency), plus 1 cycle for edge compare.
- Sample k (k=0 start, 1–8 data, 9 stop) is taken `BAUD_DIV/2 + k·BAUD_DIV` cycles after detection, i.e. mid-bit.
- `rdy` and `rx_data` update on the clock edge of the stop sample. They are visible the following cycle, about 9.5 bit periods after the line start edge.
- A low glitch shorter than `BAUD_DIV/2` cycles is rejected as a false start.

## Configuration
- `UART_FRAME_ERR_EN` defined: the `frm_err` port and its register exist.
  - Set or cleared at each stop sample.
  - Cleared on reset.
  - Not affected by `clr_rdy`.
- Not defined: no `frm_err` port and no stop-bit checking. Reception is otherwise identical.

## Test plan
- Send 0xAA at `BAUD_DIV` rate with `clr_rdy` tied to `rdy` → `rdy` is a single-cycle pulse at ~9.5 bit times and `rx_data`=0xAA, stable until the next frame completes.
- Send 0xAA then 0x55 back-to-back (zero idle) → two `rdy` pulses exactly 10·`BAUD_DIV` cycles apart, with `rx_data` 0xAA then 0x55.
- Send 0x0A then 0xBC (12-bit value 0xABC split high/low) with `clr_rdy` held 0 → `rdy` stays high from the first stop until the second start edge, goes low, then goes high again with `rx_data`=0xBC.
- Drive RX low for `BAUD_DIV/4` cycles, then high → no `rdy`, `rx_data` unchanged, FSM in IDLE.
- Assert `rst_n`=0 during data bit 4, release, then send 0x3C → `rdy`=0 and `rx_data`=0x00 during reset, then `rx_data`=0x3C after the full frame.
- With `UART_FRAME_ERR_EN`, send 0x81 with stop bit 0 → `rx_data`=0x81, `rdy`=1, `frm_err`=1; the next valid frame sets `frm_err`=0.
